// File: rtl/req_resp_initiator.sv
// req_resp_initiator: issues a burst of len requests (data = seed + index)
// over a ready/valid request channel and checks the returned responses
// against the same pattern, counting mismatched and spurious responses.
// Optional watchdog: define REQ_RESP_INITIATOR_TIMEOUT_EN to abort a burst
// that makes no progress for 255 cycles (sets timeout and pulses done).
module req_resp_initiator #(
  parameter int MAX_OUT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] seed,
  output logic       io_req_valid,
  input  logic       io_req_ready,
  output logic [7:0] io_req_bits,
  input  logic       io_resp_valid,
  output logic       io_resp_ready,
  input  logic [7:0] io_resp_bits,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_count,
  output logic [2:0] outstanding,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

  state_t     state, state_nxt;
  logic [7:0] len_q, seed_q;
  logic [7:0] sent, recv;
  logic       accept;
  logic       req_fire, resp_fire, resp_hit, resp_spur, resp_bad;
  logic       last_req;
  logic       wd_expire;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept        = (state == IDLE) && start;
  assign io_req_valid  = (state == RUN) && (sent < len_q) && (outstanding < MAX_OUT_C);
  assign io_req_bits   = seed_q + sent;
  assign io_resp_ready = (state == RUN) || (state == DRAIN);
  assign busy          = (state == RUN) || (state == DRAIN);
  assign done          = (state == DONE);

  assign req_fire  = io_req_valid && io_req_ready;
  assign resp_fire = io_resp_valid && io_resp_ready;
  assign resp_hit  = resp_fire && (outstanding != 3'd0);
  assign resp_spur = resp_fire && (outstanding == 3'd0);
  assign resp_bad  = (io_resp_bits != (seed_q + recv));
  assign last_req  = ((sent + 8'd1) == len_q);

`ifdef REQ_RESP_INITIATOR_TIMEOUT_EN
  logic [7:0] wdog;
  logic       timeout_q;

  assign wd_expire = busy && !req_fire && !resp_fire && (wdog == 8'hFF);
  assign timeout   = timeout_q;

  // Watchdog: counts idle cycles while busy, cleared by any handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog      <= 8'd0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      wdog      <= 8'd0;
      timeout_q <= 1'b0;
    end else if (busy) begin
      if (req_fire || resp_fire) begin
        wdog <= 8'd0;
      end else if (!wd_expire) begin
        wdog <= wdog + 8'd1;
      end
      if (wd_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Burst parameters captured when a start is accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      len_q  <= len;
      seed_q <= seed;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (wd_expire) begin
          state_nxt = DONE;
        end else if (req_fire && last_req) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (wd_expire) begin
          state_nxt = DONE;
        end else if ((outstanding == 3'd0) && (recv == len_q)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request/response bookkeeping and error counting
  always_ff @(posedge clk) begin
    if (reset) begin
      sent        <= 8'd0;
      recv        <= 8'd0;
      outstanding <= 3'd0;
      err_count   <= 8'd0;
    end else if (accept) begin
      sent        <= 8'd0;
      recv        <= 8'd0;
      outstanding <= 3'd0;
      err_count   <= 8'd0;
    end else begin
      if (req_fire) begin
        sent <= sent + 8'd1;
      end
      if (resp_hit) begin
        recv <= recv + 8'd1;
      end
      case ({req_fire, resp_hit})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
      if (resp_spur || (resp_hit && resp_bad)) begin
        err_count <= sat_inc8(err_count);
      end
    end
  end

endmodule

// File: tb/tb_req_resp_initiator.sv
// Directed testbench for req_resp_initiator (MAX_OUT = 2).
// The watchdog scenario is compiled only when REQ_RESP_INITIATOR_TIMEOUT_EN
// is defined.
module tb_req_resp_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic [7:0] seed;
  logic       io_req_valid;
  logic       io_req_ready;
  logic [7:0] io_req_bits;
  logic       io_resp_valid;
  logic       io_resp_ready;
  logic [7:0] io_resp_bits;
  logic       busy;
  logic       done;
  logic [7:0] err_count;
  logic [2:0] outstanding;
  logic       timeout;

  int compared   = 0;
  int mismatched = 0;

  // Results recorded by run_burst
  logic [7:0] req_log [0:15];
  int         n_req;
  int         n_done;
  int         stall_fires;
  int         stall_bad;
  logic [7:0] err_at_done;
  logic [2:0] out_at_done;
  logic       first_valid;

  req_resp_initiator #(.MAX_OUT(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .len           (len),
    .seed          (seed),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_bits   (io_req_bits),
    .io_resp_valid (io_resp_valid),
    .io_resp_ready (io_resp_ready),
    .io_resp_bits  (io_resp_bits),
    .busy          (busy),
    .done          (done),
    .err_count     (err_count),
    .outstanding   (outstanding),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  // Loopback responder with a 2-entry queue. Response index bad_idx is
  // replaced by bad_val; responses are withheld for the first stall cycles.
  task automatic run_burst(input logic [7:0] l, input logic [7:0] s,
                           input int bad_idx, input logic [7:0] bad_val,
                           input int stall);
    logic [7:0] q[$];
    int rcount;
    int done_cyc;
    rcount      = 0;
    done_cyc    = -1;
    n_req       = 0;
    n_done      = 0;
    stall_fires = -1;
    stall_bad   = 0;
    err_at_done = 8'hEE;
    out_at_done = 3'd7;
    first_valid = 1'b0;
    @(negedge clk);
    start = 1'b1; len = l; seed = s;
    io_req_ready = 1'b0; io_resp_valid = 1'b0; io_resp_bits = 8'd0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      io_req_ready  = (q.size() < 2);
      io_resp_valid = (cyc >= stall) && (q.size() > 0);
      if (q.size() > 0) begin
        io_resp_bits = (rcount == bad_idx) ? bad_val : q[0];
      end else begin
        io_resp_bits = 8'd0;
      end
      #1;
      if (cyc == 0) first_valid = io_req_valid;
      if (cyc == stall) stall_fires = n_req;
      if ((cyc < stall) && (n_req >= 2) && (io_req_valid || (outstanding != 3'd2))) begin
        stall_bad++;
      end
      if (done) begin
        n_done++;
        err_at_done = err_count;
        out_at_done = outstanding;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (io_resp_valid && io_resp_ready) begin
        void'(q.pop_front());
        rcount++;
      end
      if (io_req_valid && io_req_ready) begin
        if (n_req < 16) req_log[n_req] = io_req_bits;
        n_req++;
        q.push_back(io_req_bits);
      end
      @(negedge clk);
      if ((done_cyc >= 0) && (cyc >= done_cyc + 3)) break;
    end
    io_req_ready  = 1'b0;
    io_resp_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; len = 8'd0; seed = 8'd0;
    io_req_ready = 1'b0; io_resp_valid = 1'b0; io_resp_bits = 8'd0;
    repeat (3) @(negedge clk);
    compared++;
    if ({io_req_valid, io_resp_ready, busy, done} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b expected 0000", {io_req_valid, io_resp_ready, busy, done});
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({io_req_valid, io_resp_ready, busy, done, timeout} !== 5'b00000) begin
      mismatched++;
      $display("FAIL post_reset_ctrl: got %b expected 00000", {io_req_valid, io_resp_ready, busy, done, timeout});
    end
    compared++;
    if ({err_count, outstanding} !== 11'd0) begin
      mismatched++;
      $display("FAIL post_reset_counts: err %0d out %0d expected 0 0", err_count, outstanding);
    end
  endtask

  task automatic test_loopback;
    run_burst(8'd5, 8'h10, -1, 8'h00, 0);
    compared++;
    if (first_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL loop_latency: got valid=%b expected 1", first_valid);
    end
    compared++;
    if (n_req !== 5) begin
      mismatched++;
      $display("FAIL loop_nreq: got %0d expected 5", n_req);
    end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (req_log[i] !== 8'(8'h10 + i)) begin
        mismatched++;
        $display("FAIL loop_bits[%0d]: got %02h expected %02h", i, req_log[i], 8'(8'h10 + i));
      end
    end
    compared++;
    if (n_done !== 1) begin
      mismatched++;
      $display("FAIL loop_done_pulses: got %0d expected 1", n_done);
    end
    compared++;
    if (err_at_done !== 8'd0) begin
      mismatched++;
      $display("FAIL loop_err: got %0d expected 0", err_at_done);
    end
    compared++;
    if (out_at_done !== 3'd0) begin
      mismatched++;
      $display("FAIL loop_outstanding: got %0d expected 0", out_at_done);
    end
  endtask

  task automatic test_bad_response;
    run_burst(8'd4, 8'h10, 2, 8'hFF, 0);
    compared++;
    if (n_done !== 1) begin
      mismatched++;
      $display("FAIL bad_done_pulses: got %0d expected 1", n_done);
    end
    compared++;
    if (err_at_done !== 8'd1) begin
      mismatched++;
      $display("FAIL bad_err: got %0d expected 1", err_at_done);
    end
    repeat (4) @(negedge clk);
    #1;
    compared++;
    if ({err_count, timeout} !== {8'd1, 1'b0}) begin
      mismatched++;
      $display("FAIL err_hold: got err %0d to %b expected 1 0", err_count, timeout);
    end
  endtask

  task automatic test_stall;
    run_burst(8'd4, 8'h20, -1, 8'h00, 10);
    compared++;
    if (stall_fires !== 2) begin
      mismatched++;
      $display("FAIL stall_fires: got %0d expected 2", stall_fires);
    end
    compared++;
    if (stall_bad !== 0) begin
      mismatched++;
      $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad);
    end
    compared++;
    if ({n_req, n_done} !== {32'd4, 32'd1}) begin
      mismatched++;
      $display("FAIL stall_complete: got req %0d done %0d expected 4 1", n_req, n_done);
    end
  endtask

  task automatic test_spurious_and_abort;
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; len = 8'd2; seed = 8'h40;
    io_req_ready = 1'b0; io_resp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    io_resp_valid = 1'b1; io_resp_bits = 8'h40;
    #1;
    compared++;
    if ({io_req_valid, io_req_bits, busy} !== {1'b1, 8'h40, 1'b1}) begin
      mismatched++;
      $display("FAIL spur_run: got v=%b bits=%02h busy=%b expected 1 40 1", io_req_valid, io_req_bits, busy);
    end
    @(negedge clk);
    io_resp_valid = 1'b0;
    start = 1'b1; len = 8'd0;
    #1;
    compared++;
    if ({err_count, outstanding} !== {8'd1, 3'd0}) begin
      mismatched++;
      $display("FAIL spur_err: got err %0d out %0d expected 1 0", err_count, outstanding);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    compared++;
    if ({busy, io_req_valid, io_req_bits} !== {1'b1, 1'b1, 8'h40}) begin
      mismatched++;
      $display("FAIL start_ignored: got busy=%b v=%b bits=%02h expected 1 1 40", busy, io_req_valid, io_req_bits);
    end
    io_resp_valid = 1'b1;
    repeat (300) @(negedge clk);
    io_resp_valid = 1'b0;
    #1;
    compared++;
    if (err_count !== 8'd255) begin
      mismatched++;
      $display("FAIL err_saturate: got %0d expected 255", err_count);
    end
    io_req_ready = 1'b1;
    @(negedge clk);
    io_req_ready = 1'b0;
    #1;
    compared++;
    if (outstanding !== 3'd1) begin
      mismatched++;
      $display("FAIL abort_inflight: got %0d expected 1", outstanding);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({io_req_valid, io_resp_ready, busy, done} !== 4'b0000) begin
      mismatched++;
      $display("FAIL abort_during_reset: got %b expected 0000", {io_req_valid, io_resp_ready, busy, done});
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (done) ndone++;
      @(negedge clk);
    end
    compared++;
    if ({ndone, err_count, outstanding} !== {32'd0, 8'd0, 3'd0}) begin
      mismatched++;
      $display("FAIL abort_after: got done %0d err %0d out %0d expected 0 0 0", ndone, err_count, outstanding);
    end
  endtask

  task automatic test_len_zero;
    @(negedge clk);
    start = 1'b1; len = 8'd0; seed = 8'h55;
    @(negedge clk);
    start = 1'b0;
    #1;
    compared++;
    if ({done, io_req_valid, busy} !== 3'b100) begin
      mismatched++;
      $display("FAIL len0_done: got done=%b v=%b busy=%b expected 1 0 0", done, io_req_valid, busy);
    end
    @(negedge clk);
    #1;
    compared++;
    if ({done, io_req_valid, busy} !== 3'b000) begin
      mismatched++;
      $display("FAIL len0_after: got done=%b v=%b busy=%b expected 0 0 0", done, io_req_valid, busy);
    end
  endtask

`ifdef REQ_RESP_INITIATOR_TIMEOUT_EN
  task automatic test_timeout;
    int last_fire;
    int done_cyc;
    int ndone;
    logic to_at_done;
    last_fire = -1; done_cyc = -1; ndone = 0; to_at_done = 1'b0;
    @(negedge clk);
    start = 1'b1; len = 8'd3; seed = 8'h00;
    io_req_ready = 1'b1; io_resp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (io_req_valid && io_req_ready) last_fire = c;
      if (done) begin
        ndone++;
        to_at_done = timeout;
        if (done_cyc < 0) done_cyc = c;
      end
      @(negedge clk);
    end
    io_req_ready = 1'b0;
    compared++;
    if ((done_cyc - last_fire < 255) || (done_cyc - last_fire > 257) || (ndone != 1)) begin
      mismatched++;
      $display("FAIL wd_done: got gap %0d pulses %0d expected 255..257 1", done_cyc - last_fire, ndone);
    end
    compared++;
    if (to_at_done !== 1'b1) begin
      mismatched++;
      $display("FAIL wd_timeout: got %b expected 1", to_at_done);
    end
    ndone = 0;
    @(negedge clk);
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (done) ndone++;
      @(negedge clk);
    end
    compared++;
    if ({ndone, busy, timeout} !== {32'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL wd_abort: got done %0d busy %b to %b expected 0 0 0", ndone, busy, timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_bad_response();
    test_stall();
    test_spurious_and_abort();
    test_len_zero();
`ifdef REQ_RESP_INITIATOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/req_resp_initiator.md
REQ_RESP_INITIATOR -- requirements
Module: req_resp_initiator

Interface
REQ-001 SHALL have parameter MAX_OUT, default 2, maximum requests in flight (1..7).
REQ-002 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit, begins a transaction burst; sampled only in IDLE.
REQ-005 SHALL have port len, input, 8 bits, number of requests in the burst; sampled with start.
REQ-006 SHALL have port seed, input, 8 bits, data pattern base; sampled with start.
REQ-007 SHALL have ports io_req_valid (output, 1), io_req_ready (input, 1) and io_req_bits (output, 8), the request ready/valid producer side.
REQ-008 SHALL have ports io_resp_valid (input, 1), io_resp_ready (output, 1) and io_resp_bits (input, 8), the response ready/valid consumer side.
REQ-009 SHALL have port busy, output, 1 bit, high in RUN or DRAIN.
REQ-010 SHALL have port done, output, 1 bit, one-cycle pulse at burst completion.
REQ-011 SHALL have port err_count, output, 8 bits, count of mismatched or spurious responses, saturating.
REQ-012 SHALL have port outstanding, output, 3 bits, the current number of requests in flight.
REQ-013 SHALL have port timeout, output, 1 bit, watchdog expiry flag.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-015 SHALL, on IDLE with start=1, latch len and seed, clear the counters and err_count, and enter RUN next cycle; if len=0, it SHALL enter DONE instead.
REQ-016 SHALL drive io_req_valid = (state==RUN) && (sent<len) && (outstanding<MAX_OUT).
REQ-017 SHALL drive io_req_bits = seed + sent[7:0], mod 256, and hold it stable while valid && !ready.
REQ-018 SHALL count a req fire (valid && ready): sent+1 and outstanding+1.
REQ-019 SHALL drive io_resp_ready=1 in RUN and DRAIN, and 0 in IDLE and DONE.
REQ-020 SHALL count a resp fire with outstanding>0: outstanding-1 and recv+1; if resp_bits != seed+recv[7:0], it SHALL increment err_count.
REQ-021 SHALL treat a resp fire with outstanding=0 as spurious: increment err_count, leave outstanding and recv unchanged.
REQ-022 SHALL leave outstanding unchanged on a simultaneous req fire and valid resp fire, and advance both sent and recv.
REQ-023 SHALL saturate err_count at 255.
REQ-024 SHALL move from RUN to DRAIN in the cycle after the fire that makes sent==len.
REQ-025 SHALL move from DRAIN to DONE when outstanding==0 and recv==len.
REQ-026 SHALL stay in DONE for exactly one cycle with done=1, then return to IDLE.
REQ-027 SHALL hold err_count and timeout until the next accepted start.
REQ-028 SHALL ignore start outside IDLE.
REQ-029 SHALL drive busy = (state==RUN || state==DRAIN).
REQ-030 SHALL have a start-to-first-io_req_valid latency of 1 cycle.

Reset
REQ-031 SHALL, on reset, go to IDLE and clear sent, recv, outstanding, err_count and timeout.
REQ-032 SHALL drive io_req_valid=0, io_resp_ready=0, busy=0 and done=0 during and after reset.
REQ-033 SHALL abort a burst on reset mid-operation with no done pulse; in-flight responses are discarded.

Configuration
REQ-034 SHALL, with REQ_RESP_INITIATOR_TIMEOUT_EN defined, run an 8-bit watchdog in RUN and DRAIN that clears on any req or resp fire and increments otherwise.
REQ-035 SHALL, at watchdog count 255 with the macro defined, set timeout=1 and enter DONE, pulsing done.
REQ-036 SHALL, without the macro, tie timeout to 0 and include no watchdog logic.

Verification
REQ-037 SHALL cover: loopback via a 2-entry queue, len=5, seed=0x10, resp_ready path always ready -> req bits 0x10..0x14, done pulse once, err_count=0, outstanding=0 at done.
REQ-038 SHALL cover: responder returns 0x10,0x11,0xFF,0x13 for len=4, seed=0x10 -> err_count=1, done pulses.
REQ-039 SHALL cover: MAX_OUT=2 with responder stalled 10 cycles, len=4 -> exactly 2 fires, then io_req_valid=0 and outstanding=2 until the first response.
REQ-040 SHALL cover: spurious io_resp_valid in RUN with outstanding=0 -> err_count increments, outstanding stays 0.
REQ-041 SHALL cover: start with len=0 -> DONE next cycle, done pulse, no io_req_valid.
REQ-042 SHALL cover, with TIMEOUT_EN: len=3, responder never valid -> timeout=1 and a done pulse 255 cycles after the last fire; reset mid-burst -> IDLE, no done pulse.
